fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the decode stage. It holds the program counter, issues one instruction-memory request at a time, and presents the returned instruction to decode together with `pc`/`pc+4`. In the cycle the instruction is consumed, it samples decode's PC-redirect outputs (`pc_mux`, branch offset) to form the next PC. Single-issue and non-speculative: at most one request is outstanding, and nothing is fetched past an unresolved instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clock` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `instr_req_op` out 1: instruction-memory read request.
- `instr_addr_op` out 32: byte address of request; equals `pc_op`.
- `instr_rvalid_ip` in 1: memory read data valid.
- `instr_rdata_ip` in 32: memory read data.
- `stall_ip` in 1: downstream not ready; hold current instruction.
- `pc_mux_ip` in `pc_mux`: NEXTPC or OFFSET, from decode.
- `pc_branch_offset_ip` in 32: signed byte offset from decode, used when OFFSET.
- `pc_op` out 32: PC of instruction presented.
- `pc4_op` out 32: `pc_op + 4`, combinational, mod 2^32.
- `instr_data_valid_op` out 1: `instr_data_op` is a valid instruction.
- `instr_data_op` out 32: latched instruction word.
- `misaligned_op` out 1: sticky, redirect target not word-aligned.
- `retired_count_op` out 32: instructions consumed since reset, wraps.

## Operation
- FSM states: BOOT, REQ, VALID, HALT. Reset state BOOT.
- **BOOT**:
  - all outputs at reset values;
  - unconditional transition to REQ next cycle;
  - `instr_rvalid_ip` ignored, so stale responses after a reset are dropped.
- **REQ**:
  - `instr_req_op`=1, `instr_addr_op`=`pc_op`.
  - On `instr_rvalid_ip`=1: latch `instr_rdata_ip` into the instruction register and go to VALID.
  - Otherwise stay; no timeout.
  - Same-cycle response (rvalid in the first REQ cycle) is legal.
- **VALID**:
  - `instr_data_valid_op`=1, `instr_req_op`=0.
  - If `stall_ip`=1: hold all state; `pc_mux_ip` is not sampled.
  - If `stall_ip`=0 (consume):
    - compute target: NEXTPC gives `pc_op+4`; OFFSET gives `pc_op + pc_branch_offset_ip`, 32-bit wrap, offset treated as two's complement;
    - `retired_count_op` increments (wraps 0xFFFF_FFFF to 0);
    - if target[1:0]==0: `pc_op` takes target, go to REQ;
    - else: `pc_op` unchanged, `misaligned_op` set to 1, go to HALT.
- **HALT**:
  - `instr_req_op`=0, `instr_data_valid_op`=0;
  - `misaligned_op`=1;
  - remains until reset.
- `instr_rvalid_ip` outside REQ is ignored; `instr_rdata_ip` is sampled only on an accepted rvalid.
- Unknown `pc_mux_ip` encodings are treated as NEXTPC.

## Timing
- Reset values:
  - `pc_op`=`RESET_PC`, `pc4_op`=`RESET_PC`+4, `instr_addr_op`=`RESET_PC`;
  - `instr_req_op`=0, `instr_data_valid_op`=0, `instr_data_op`=0;
  - `misaligned_op`=0, `retired_count_op`=0.
- Reset deasserted before edge 0:
  - edge 0 → REQ, so `instr_req_op`=1 in cycle 1.
- rvalid sampled at the end of cycle k:
  - `instr_data_valid_op`=1 from cycle k+1.
- Consume at end of cycle v:
  - new `pc_op` and `instr_req_op`=1 in cycle v+1.
- Best-case throughput: one instruction per 2 cycles (REQ, VALID).
- Decode is combinational. `pc_mux_ip` and `pc_branch_offset_ip` must be stable in the VALID cycle and are registered only at the consume edge.
- `pc_op`, `instr_data_op`, `instr_data_valid_op` are registered; only `pc4_op` and `instr_addr_op` (= `pc_op`) are combinational from state.
- Reset asserted mid-operation (any state, including outstanding REQ): outputs go to reset values asynchronously, with no glitch-free requirement on the same cycle.

## Test plan
- **Reset/boot**: `RESET_PC`=0x100, release reset, memory returns 0x00500093 with 2-cycle latency → `instr_req_op` rises in cycle 1 with addr 0x100; `instr_data_valid_op`=1 with data 0x00500093, `pc_op`=0x100, `pc4_op`=0x104.
- **Sequential**: three NEXTPC consumes with 0-latency memory → addresses 0x100, 0x104, 0x108; 2 cycles per instruction; `retired_count_op`=3.
- **Stall**: `stall_ip`=1 for 4 VALID cycles with `pc_mux_ip`=OFFSET toggling → instruction, PC and count held, no request; release with NEXTPC → next addr `pc+4`.
- **Jump**:
  - `pc_op`=0x200, OFFSET, offset 0xFFFF_FFF0 → next request addr 0x1F0;
  - `pc_op`=0xFFFF_FFFC, offset 8 → addr 0x4 (wrap).
- **Misaligned**: `pc_op`=0x200, OFFSET, offset 0x6 → `misaligned_op`=1, `pc_op` stays 0x200, no further requests for 20 cycles; reset clears the flag.
- **Reset mid-REQ**: assert reset while a request is outstanding; memory's rvalid arrives during BOOT → ignored; fresh request to `RESET_PC` in the cycle after BOOT.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, the
// instruction handed to decode, and decode's PC-redirect inputs.
// The fetch unit uses the master view; memory/decode use the slave view.
interface fetch_unit_if;
    logic        instr_req_op;
    logic [31:0] instr_addr_op;
    logic        instr_rvalid_ip;
    logic [31:0] instr_rdata_ip;
    logic        stall_ip;
    logic        pc_mux_ip;
    logic [31:0] pc_branch_offset_ip;
    logic [31:0] pc_op;
    logic [31:0] pc4_op;
    logic        instr_data_valid_op;
    logic [31:0] instr_data_op;
    logic        misaligned_op;
    logic [31:0] retired_count_op;

    modport master (
        output instr_req_op,
        output instr_addr_op,
        input  instr_rvalid_ip,
        input  instr_rdata_ip,
        input  stall_ip,
        input  pc_mux_ip,
        input  pc_branch_offset_ip,
        output pc_op,
        output pc4_op,
        output instr_data_valid_op,
        output instr_data_op,
        output misaligned_op,
        output retired_count_op
    );

    modport slave (
        input  instr_req_op,
        input  instr_addr_op,
        output instr_rvalid_ip,
        output instr_rdata_ip,
        output stall_ip,
        output pc_mux_ip,
        output pc_branch_offset_ip,
        input  pc_op,
        input  pc4_op,
        input  instr_data_valid_op,
        input  instr_data_op,
        input  misaligned_op,
        input  retired_count_op
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-issue, non-speculative instruction fetch stage.
// Holds the PC, issues one memory read at a time, presents the returned
// word to decode, and forms the next PC from decode's redirect inputs
// in the cycle the instruction is consumed. A redirect to a non-word-
// aligned target parks the unit in HALT until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clock,
    input  logic         reset,
    fetch_unit_if.master bus
);

    // pc_mux encoding from decode; anything other than OFFSET means NEXTPC.
    localparam logic PC_MUX_OFFSET = 1'b1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;
    logic        r_misaligned;

    logic        w_loadInstr;
    logic        w_consume;
    logic        w_req;
    logic        w_dataValid;
    logic [31:0] w_target;
    logic        w_targetAligned;

    // Next PC candidate; only meaningful in the consume cycle.
    assign w_target        = (bus.pc_mux_ip == PC_MUX_OFFSET) ?
                             (r_pc + bus.pc_branch_offset_ip) : (r_pc + 32'd4);
    assign w_targetAligned = (w_target[1:0] == 2'b00);

    // State register; reset lands in BOOT so stale responses are dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and per-state control strobes.
    always_comb begin
        w_nextState = r_state;
        w_loadInstr = 1'b0;
        w_consume   = 1'b0;
        w_req       = 1'b0;
        w_dataValid = 1'b0;
        case (r_state)
            BOOT: begin
                w_nextState = REQ;
            end
            REQ: begin
                w_req = 1'b1;
                if (bus.instr_rvalid_ip) begin
                    w_loadInstr = 1'b1;
                    w_nextState = VALID;
                end
            end
            VALID: begin
                w_dataValid = 1'b1;
                if (!bus.stall_ip) begin
                    w_consume   = 1'b1;
                    w_nextState = w_targetAligned ? REQ : HALT;
                end
            end
            HALT: begin
                w_nextState = HALT;
            end
            default: begin
                w_nextState = BOOT;
            end
        endcase
    end

    // PC advances on an aligned consume; a misaligned target freezes the PC
    // and raises the sticky flag instead.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_misaligned <= 1'b0;
        end else if (w_consume) begin
            if (w_targetAligned) begin
                r_pc <= w_target;
            end else begin
                r_misaligned <= 1'b1;
            end
        end
    end

    // Instruction register captures read data only on an accepted response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_instr <= 32'h0;
        end else if (w_loadInstr) begin
            r_instr <= bus.instr_rdata_ip;
        end
    end

    // Retired counter counts every consume, including one that halts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_retired <= 32'h0;
        end else if (w_consume) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign bus.instr_req_op        = w_req;
    assign bus.instr_addr_op       = r_pc;
    assign bus.pc_op               = r_pc;
    assign bus.pc4_op              = r_pc + 32'd4;
    assign bus.instr_data_valid_op = w_dataValid;
    assign bus.instr_data_op       = r_instr;
    assign bus.misaligned_op       = r_misaligned;
    assign bus.retired_count_op    = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with RESET_PC = 0x100. Each scenario
// task drives the bus by hand and compares against hand-computed values.
module tb_fetch_unit;

    localparam logic MUX_NEXTPC = 1'b0;
    localparam logic MUX_OFFSET = 1'b1;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;
    int   cycle;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // 10-time-unit clock; rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Free-running cycle counter used to measure request spacing.
    initial cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    // Advance one cycle and settle just past the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for a request, hold off 'latency' cycles, then return data.
    task automatic serve(input logic [31:0] data, input int latency,
                         output logic [31:0] addr, output int reqCycle);
        int n;
        n = 0;
        while (bus.instr_req_op !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        if (bus.instr_req_op !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL serve_timeout req=%b want 1", bus.instr_req_op);
        end
        addr     = bus.instr_addr_op;
        reqCycle = cycle;
        repeat (latency) tick();
        bus.instr_rvalid_ip = 1'b1;
        bus.instr_rdata_ip  = data;
        tick();
        bus.instr_rvalid_ip = 1'b0;
        bus.instr_rdata_ip  = 32'h0;
    endtask

    // Let decode consume the presented instruction with the given redirect.
    task automatic consume(input logic mux, input logic [31:0] offset);
        bus.stall_ip            = 1'b0;
        bus.pc_mux_ip           = mux;
        bus.pc_branch_offset_ip = offset;
        tick();
        bus.pc_mux_ip           = MUX_NEXTPC;
        bus.pc_branch_offset_ip = 32'h0;
    endtask

    // Reset values, then boot fetch with a 2-cycle memory.
    task automatic test_reset();
        logic [31:0] a;
        int c;
        vectors++; if (bus.pc_op !== 32'h100) begin miscompares++; $display("[TB] FAIL rst_pc got %h want %h", bus.pc_op, 32'h100); end
        vectors++; if (bus.pc4_op !== 32'h104) begin miscompares++; $display("[TB] FAIL rst_pc4 got %h want %h", bus.pc4_op, 32'h104); end
        vectors++; if (bus.instr_addr_op !== 32'h100) begin miscompares++; $display("[TB] FAIL rst_addr got %h want %h", bus.instr_addr_op, 32'h100); end
        vectors++; if ({bus.instr_req_op, bus.instr_data_valid_op, bus.misaligned_op} !== 3'b000) begin miscompares++; $display("[TB] FAIL rst_flags got %b want 000", {bus.instr_req_op, bus.instr_data_valid_op, bus.misaligned_op}); end
        vectors++; if (bus.instr_data_op !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_data got %h want 0", bus.instr_data_op); end
        vectors++; if (bus.retired_count_op !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_retired got %h want 0", bus.retired_count_op); end
        tick();
        vectors++; if (bus.instr_req_op !== 1'b1 || bus.instr_addr_op !== 32'h100) begin miscompares++; $display("[TB] FAIL boot_req got req=%b addr=%h want req=1 addr=100", bus.instr_req_op, bus.instr_addr_op); end
        serve(32'h0050_0093, 2, a, c);
        vectors++; if (a !== 32'h100) begin miscompares++; $display("[TB] FAIL boot_fetch_addr got %h want 100", a); end
        vectors++; if (bus.instr_data_valid_op !== 1'b1 || bus.instr_req_op !== 1'b0) begin miscompares++; $display("[TB] FAIL boot_valid got valid=%b req=%b want 1/0", bus.instr_data_valid_op, bus.instr_req_op); end
        vectors++; if (bus.instr_data_op !== 32'h0050_0093) begin miscompares++; $display("[TB] FAIL boot_data got %h want 00500093", bus.instr_data_op); end
        vectors++; if (bus.pc_op !== 32'h100 || bus.pc4_op !== 32'h104) begin miscompares++; $display("[TB] FAIL boot_pc got %h/%h want 100/104", bus.pc_op, bus.pc4_op); end
    endtask

    // Three NEXTPC consumes with a zero-latency memory.
    task automatic test_sequential();
        logic [31:0] a;
        int c0;
        int c1;
        consume(MUX_NEXTPC, 32'h0);
        serve(32'h0010_0113, 0, a, c0);
        vectors++; if (a !== 32'h104) begin miscompares++; $display("[TB] FAIL seq_addr1 got %h want 104", a); end
        vectors++; if (bus.instr_data_op !== 32'h0010_0113) begin miscompares++; $display("[TB] FAIL seq_data1 got %h want 00100113", bus.instr_data_op); end
        consume(MUX_NEXTPC, 32'h0);
        serve(32'h0020_0193, 0, a, c1);
        vectors++; if (a !== 32'h108) begin miscompares++; $display("[TB] FAIL seq_addr2 got %h want 108", a); end
        vectors++; if (c1 - c0 !== 2) begin miscompares++; $display("[TB] FAIL seq_spacing got %0d want 2", c1 - c0); end
        consume(MUX_NEXTPC, 32'h0);
        vectors++; if (bus.retired_count_op !== 32'd3) begin miscompares++; $display("[TB] FAIL seq_retired got %0d want 3", bus.retired_count_op); end
        vectors++; if (bus.instr_req_op !== 1'b1 || bus.pc_op !== 32'h10C) begin miscompares++; $display("[TB] FAIL seq_next got req=%b pc=%h want 1/10c", bus.instr_req_op, bus.pc_op); end
    endtask

    // Four stalled VALID cycles with pc_mux toggling must change nothing.
    task automatic test_stall();
        logic [31:0] a;
        int c;
        serve(32'h1111_1111, 1, a, c);
        vectors++; if (a !== 32'h10C) begin miscompares++; $display("[TB] FAIL stall_fetch_addr got %h want 10c", a); end
        for (int i = 0; i < 4; i++) begin
            bus.stall_ip            = 1'b1;
            bus.pc_mux_ip           = (i % 2 == 0) ? MUX_OFFSET : MUX_NEXTPC;
            bus.pc_branch_offset_ip = 32'h40;
            tick();
            vectors++;
            if ({bus.instr_data_valid_op, bus.instr_req_op, bus.pc_op, bus.instr_data_op, bus.retired_count_op} !==
                {1'b1, 1'b0, 32'h10C, 32'h1111_1111, 32'd3}) begin
                miscompares++;
                $display("[TB] FAIL stall_hold%0d got v=%b r=%b pc=%h d=%h n=%0d want 1/0/10c/11111111/3",
                         i, bus.instr_data_valid_op, bus.instr_req_op, bus.pc_op, bus.instr_data_op, bus.retired_count_op);
            end
        end
        consume(MUX_NEXTPC, 32'h0);
        vectors++; if (bus.instr_req_op !== 1'b1 || bus.instr_addr_op !== 32'h110) begin miscompares++; $display("[TB] FAIL stall_release got req=%b addr=%h want 1/110", bus.instr_req_op, bus.instr_addr_op); end
        vectors++; if (bus.retired_count_op !== 32'd4) begin miscompares++; $display("[TB] FAIL stall_retired got %0d want 4", bus.retired_count_op); end
    endtask

    // Backward jump and a forward jump that wraps past 2^32.
    task automatic test_jump();
        logic [31:0] a;
        int c;
        serve(32'h0000_0013, 0, a, c);
        consume(MUX_OFFSET, 32'h0000_00F0);
        vectors++; if (bus.instr_addr_op !== 32'h200) begin miscompares++; $display("[TB] FAIL jump_fwd got %h want 200", bus.instr_addr_op); end
        serve(32'h0000_0013, 0, a, c);
        consume(MUX_OFFSET, 32'hFFFF_FFF0);
        vectors++; if (bus.instr_addr_op !== 32'h1F0 || bus.instr_req_op !== 1'b1) begin miscompares++; $display("[TB] FAIL jump_back got req=%b addr=%h want 1/1f0", bus.instr_req_op, bus.instr_addr_op); end
        serve(32'h0000_0013, 0, a, c);
        consume(MUX_OFFSET, 32'hFFFF_FE0C);
        vectors++; if (bus.instr_addr_op !== 32'hFFFF_FFFC) begin miscompares++; $display("[TB] FAIL jump_top got %h want fffffffc", bus.instr_addr_op); end
        vectors++; if (bus.pc4_op !== 32'h0) begin miscompares++; $display("[TB] FAIL pc4_wrap got %h want 0", bus.pc4_op); end
        serve(32'h0000_0013, 0, a, c);
        consume(MUX_OFFSET, 32'h0000_0008);
        vectors++; if (bus.instr_addr_op !== 32'h4) begin miscompares++; $display("[TB] FAIL jump_wrap got %h want 4", bus.instr_addr_op); end
        vectors++; if (bus.retired_count_op !== 32'd8 || bus.misaligned_op !== 1'b0) begin miscompares++; $display("[TB] FAIL jump_state got n=%0d mis=%b want 8/0", bus.retired_count_op, bus.misaligned_op); end
    endtask

    // Misaligned redirect halts fetch until reset clears it.
    task automatic test_misaligned();
        logic [31:0] a;
        int c;
        int reqSeen;
        serve(32'h0000_0013, 0, a, c);
        consume(MUX_OFFSET, 32'h0000_01FC);
        vectors++; if (bus.instr_addr_op !== 32'h200) begin miscompares++; $display("[TB] FAIL mis_setup got %h want 200", bus.instr_addr_op); end
        serve(32'h0000_0013, 0, a, c);
        consume(MUX_OFFSET, 32'h0000_0006);
        vectors++; if (bus.misaligned_op !== 1'b1 || bus.pc_op !== 32'h200) begin miscompares++; $display("[TB] FAIL mis_flag got mis=%b pc=%h want 1/200", bus.misaligned_op, bus.pc_op); end
        vectors++; if (bus.instr_req_op !== 1'b0 || bus.instr_data_valid_op !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_outputs got req=%b valid=%b want 0/0", bus.instr_req_op, bus.instr_data_valid_op); end
        vectors++; if (bus.retired_count_op !== 32'd10) begin miscompares++; $display("[TB] FAIL mis_retired got %0d want 10", bus.retired_count_op); end
        reqSeen = 0;
        for (int i = 0; i < 20; i++) begin
            bus.instr_rvalid_ip = (i % 3 == 0);
            tick();
            if (bus.instr_req_op !== 1'b0 || bus.instr_data_valid_op !== 1'b0) reqSeen++;
        end
        bus.instr_rvalid_ip = 1'b0;
        vectors++; if (reqSeen !== 0) begin miscompares++; $display("[TB] FAIL halt_quiet got %0d active cycles want 0", reqSeen); end
        vectors++; if (bus.misaligned_op !== 1'b1 || bus.pc_op !== 32'h200) begin miscompares++; $display("[TB] FAIL halt_sticky got mis=%b pc=%h want 1/200", bus.misaligned_op, bus.pc_op); end
        reset = 1'b1;
        #2;
        vectors++; if (bus.misaligned_op !== 1'b0 || bus.pc_op !== 32'h100 || bus.retired_count_op !== 32'h0) begin miscompares++; $display("[TB] FAIL halt_reset got mis=%b pc=%h n=%0d want 0/100/0", bus.misaligned_op, bus.pc_op, bus.retired_count_op); end
        tick();
        reset = 1'b0;
        tick();
        vectors++; if (bus.instr_req_op !== 1'b1 || bus.instr_addr_op !== 32'h100) begin miscompares++; $display("[TB] FAIL halt_reboot got req=%b addr=%h want 1/100", bus.instr_req_op, bus.instr_addr_op); end
    endtask

    // Reset while a request is outstanding; late response lands in BOOT.
    task automatic test_reset_mid_req();
        logic [31:0] a;
        int c;
        serve(32'h2222_2222, 0, a, c);
        consume(MUX_NEXTPC, 32'h0);
        vectors++; if (bus.instr_req_op !== 1'b1 || bus.instr_addr_op !== 32'h104) begin miscompares++; $display("[TB] FAIL mid_pending got req=%b addr=%h want 1/104", bus.instr_req_op, bus.instr_addr_op); end
        tick();
        reset = 1'b1;
        #1;
        vectors++; if (bus.instr_req_op !== 1'b0 || bus.pc_op !== 32'h100 || bus.instr_data_op !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_async got req=%b pc=%h d=%h want 0/100/0", bus.instr_req_op, bus.pc_op, bus.instr_data_op); end
        tick();
        reset = 1'b0;
        bus.instr_rvalid_ip = 1'b1;
        bus.instr_rdata_ip  = 32'hDEAD_BEEF;
        tick();
        bus.instr_rvalid_ip = 1'b0;
        bus.instr_rdata_ip  = 32'h0;
        vectors++; if (bus.instr_req_op !== 1'b1 || bus.instr_addr_op !== 32'h100) begin miscompares++; $display("[TB] FAIL mid_refetch got req=%b addr=%h want 1/100", bus.instr_req_op, bus.instr_addr_op); end
        vectors++; if (bus.instr_data_valid_op !== 1'b0 || bus.instr_data_op !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_stale got valid=%b d=%h want 0/0", bus.instr_data_valid_op, bus.instr_data_op); end
        tick();
        vectors++; if (bus.instr_data_valid_op !== 1'b0 || bus.instr_req_op !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_waiting got valid=%b req=%b want 0/1", bus.instr_data_valid_op, bus.instr_req_op); end
    endtask

    // Scenario sequence; each scenario picks up where the previous left off.
    initial begin
        vectors                 = 0;
        miscompares             = 0;
        reset                   = 1'b1;
        bus.instr_rvalid_ip     = 1'b0;
        bus.instr_rdata_ip      = 32'h0;
        bus.stall_ip            = 1'b0;
        bus.pc_mux_ip           = MUX_NEXTPC;
        bus.pc_branch_offset_ip = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_misaligned();
        test_reset_mid_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
